// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared constants for the SPI register responder
package spi_slave_pkg;

   localparam int HDR_BITS_DEF = 16;
   localparam int DAT_BITS_DEF = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // The R/W flag is the first header bit on the wire.
   function automatic int rw_bit(input int hdr_bits);
      return hdr_bits - 1;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with a compare stage for rise/fall strobes
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~sync_q[2];
   assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI responder (16-bit header, 8-bit data) over a small register file
module spi_slave_regs
   import spi_slave_pkg::*;
#(
   parameter int                  HDR_BITS = HDR_BITS_DEF,
   parameter int                  DAT_BITS = DAT_BITS_DEF,
   parameter int                  ADDR_W   = 5,
   parameter logic [DAT_BITS-1:0] CHIP_ID  = 8'hA5
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                spi_cs_i,
   input  logic                spi_clk_i,
   input  logic                spi_mosi_i,
   output logic                spi_miso_o,
   output logic                spi_miso_t,
   input  logic [ADDR_W-1:0]   reg_addr_i,
   output logic [DAT_BITS-1:0] reg_rdata_o,
   output logic                wr_stb_o,
   output logic [ADDR_W-1:0]   wr_addr_o,
   output logic [DAT_BITS-1:0] wr_data_o,
   output logic                frm_err_o
);

   localparam int TOTAL = HDR_BITS + DAT_BITS;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int NREG  = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(HDR_BITS);
   localparam logic [CNT_W-1:0] CNT_TOT = CNT_W'(TOTAL);

   logic cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;
   logic cs_level_unused, sck_level_unused, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
      .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi_cs_i),
      .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b1)) u_sck (
      .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi_clk_i),
      .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
   );
   spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
      .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi_mosi_i),
      .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [HDR_BITS-2:0] hdr_q, hdr_d;
   logic [DAT_BITS-2:0] dat_q, dat_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DAT_BITS-1:0] tx_q, tx_d;
   logic                miso_q, miso_d, miso_t_q, miso_t_d;
   logic                wr_stb_q, wr_stb_d, frm_err_q, frm_err_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DAT_BITS-1:0] wr_data_q, wr_data_d, rdata_q, rdata_d;
   logic [DAT_BITS-1:0] regs_q [NREG];
   logic [DAT_BITS-1:0] regs_d [NREG];

   function automatic logic [DAT_BITS-1:0] reg_val(input logic [ADDR_W-1:0] a);
      return (a == '0) ? CHIP_ID : regs_q[a];
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cnt_inc   = cnt_q + CNT_W'(1);
      hdr_d     = hdr_q;
      dat_d     = dat_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      miso_t_d  = miso_t_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      frm_err_d = 1'b0;
      regs_d    = regs_q;
      // Sampled before any commit of this cycle lands, so a colliding write returns the old value.
      rdata_d   = reg_val(reg_addr_i);

      case (state_q)
         ST_IDLE: begin
            cnt_d    = '0;
            miso_t_d = 1'b1;
            if (cs_fall) state_d = ST_HDR;
         end
         ST_HDR: begin
            if (cs_rise) begin
               frm_err_d = 1'b1;
               miso_t_d  = 1'b1;
               state_d   = ST_IDLE;
            end else if (sck_rise) begin
               hdr_d = {hdr_q[HDR_BITS-3:0], mosi_s};
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_HDR) begin
                  rw_d     = hdr_q[rw_bit(HDR_BITS)-1];
                  addr_d   = {hdr_q[ADDR_W-2:0], mosi_s};
                  tx_d     = reg_val(addr_d);
                  miso_t_d = (rw_d != RW_READ);
                  state_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (cs_rise) begin
               frm_err_d = 1'b1;
               miso_t_d  = 1'b1;
               state_d   = ST_IDLE;
            end else if (sck_rise) begin
               cnt_d = cnt_inc;
               dat_d = {dat_q[DAT_BITS-3:0], mosi_s};
               if (cnt_inc == CNT_TOT) begin
                  state_d = ST_DONE;
                  if (rw_q == RW_WRITE && addr_q != '0) begin
                     regs_d[addr_q] = {dat_q, mosi_s};
                     wr_addr_d      = addr_q;
                     wr_data_d      = {dat_q, mosi_s};
                     wr_stb_d       = 1'b1;
                  end
               end
            end else if (sck_fall && rw_q == RW_READ) begin
               miso_d = tx_q[DAT_BITS-1];
               tx_d   = {tx_q[DAT_BITS-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               miso_t_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hdr_q     <= '0;
         dat_q     <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         tx_q      <= '0;
         miso_q    <= 1'b0;
         miso_t_q  <= 1'b1;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         frm_err_q <= 1'b0;
         rdata_q   <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         dat_q     <= dat_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         tx_q      <= tx_d;
         miso_q    <= miso_d;
         miso_t_q  <= miso_t_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         frm_err_q <= frm_err_d;
         rdata_q   <= rdata_d;
         regs_q    <= regs_d;
      end
   end

   assign spi_miso_o  = miso_q;
   assign spi_miso_t  = miso_t_q;
   assign reg_rdata_o = rdata_q;
   assign wr_stb_o    = wr_stb_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign frm_err_o   = frm_err_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - table-driven self-checking bench for spi_slave_regs
module tb_spi_slave_regs;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rstn;
   logic       spi_cs, spi_clk, spi_mosi;
   logic       spi_miso_o, spi_miso_t;
   logic [4:0] reg_addr;
   logic [7:0] reg_rdata;
   logic       wr_stb;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       frm_err;

   always #5 clk = ~clk;

   spi_slave_regs dut (
      .clk_i(clk), .rstn_i(rstn),
      .spi_cs_i(spi_cs), .spi_clk_i(spi_clk), .spi_mosi_i(spi_mosi),
      .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
      .reg_addr_i(reg_addr), .reg_rdata_o(reg_rdata),
      .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .frm_err_o(frm_err)
   );

   int checks = 0;
   int failures = 0;
   int stb_cnt = 0, frm_cnt = 0, t_low_cnt = 0;

   typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;
   wr_t sb_q[$];
   wr_t mon_e;

   typedef struct { logic rd; logic [4:0] addr; logic [7:0] data; logic [7:0] exp; } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (wr_stb) begin
            stb_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_wr_stb: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
               mon_e = sb_q.pop_front();
               check("sb_wr_addr", 32'(wr_addr), 32'(mon_e.addr));
               check("sb_wr_data", 32'(wr_data), 32'(mon_e.data));
            end
         end
         if (frm_err) frm_cnt++;
         if (!spi_miso_t) t_low_cnt++;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sck_bit(input logic b, output logic s_miso, output logic s_t);
      spi_clk  = 1'b0;
      spi_mosi = b;
      wait_clk(HALF);
      s_miso  = spi_miso_o;
      s_t     = spi_miso_t;
      spi_clk = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic spi_frame(input logic [23:0] word, input int ncyc,
                            output logic [7:0] rd, output logic hdr_t_hi, output logic dat_t_lo);
      logic m, t;
      rd = '0;
      hdr_t_hi = 1'b1;
      dat_t_lo = 1'b1;
      spi_cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < ncyc; i++) begin
         sck_bit((i < 24) ? word[23-i] : 1'b0, m, t);
         if (i < 16) hdr_t_hi &= t;
         else if (i < 24) begin
            dat_t_lo &= ~t;
            rd = {rd[6:0], m};
         end
      end
      wait_clk(HALF);
      spi_cs = 1'b1;
      wait_clk(12);
   endtask

   task automatic local_read(input logic [4:0] a, input logic [7:0] exp, input string name);
      reg_addr = a;
      wait_clk(2);
      check(name, 32'(reg_rdata), 32'(exp));
   endtask

   initial begin
      logic [23:0] word;
      logic [7:0]  rd;
      logic        th, tl, m, t;
      int          s0, f0, t0;

      vecs[0]  = '{1'b0, 5'h12, 8'h3C, 8'h3C};
      vecs[1]  = '{1'b1, 5'h12, 8'h00, 8'h3C};
      vecs[2]  = '{1'b1, 5'h00, 8'h00, 8'hA5};
      vecs[3]  = '{1'b0, 5'h00, 8'hFF, 8'hA5};
      vecs[4]  = '{1'b1, 5'h00, 8'h00, 8'hA5};
      vecs[5]  = '{1'b0, 5'h1F, 8'h81, 8'h81};
      vecs[6]  = '{1'b1, 5'h1F, 8'h00, 8'h81};
      vecs[7]  = '{1'b0, 5'h03, 8'h55, 8'h55};
      vecs[8]  = '{1'b1, 5'h03, 8'h00, 8'h55};
      vecs[9]  = '{1'b1, 5'h07, 8'h00, 8'h00};
      vecs[10] = '{1'b0, 5'h12, 8'hC3, 8'hC3};
      vecs[11] = '{1'b1, 5'h12, 8'h00, 8'hC3};

      rstn = 1'b0; spi_cs = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0; reg_addr = '0;
      wait_clk(5);
      check("rst_miso_o", 32'(spi_miso_o), 0);
      check("rst_miso_t", 32'(spi_miso_t), 1);
      check("rst_wr_stb", 32'(wr_stb), 0);
      check("rst_frm_err", 32'(frm_err), 0);
      check("rst_rdata", 32'(reg_rdata), 0);
      rstn = 1'b1;
      wait_clk(4);
      local_read(5'h00, 8'hA5, "chip_id_local");
      local_read(5'h12, 8'h00, "reg12_reset_local");

      for (int k = 0; k < 12; k++) begin
         s0 = stb_cnt; f0 = frm_cnt; t0 = t_low_cnt;
         word = {vecs[k].rd, 10'b0, vecs[k].addr, vecs[k].rd ? 8'h00 : vecs[k].data};
         if (!vecs[k].rd && vecs[k].addr != 5'h00) sb_q.push_back('{vecs[k].addr, vecs[k].data});
         spi_frame(word, 24, rd, th, tl);
         check($sformatf("vec%0d_frm_err", k), 32'(frm_cnt - f0), 0);
         if (vecs[k].rd) begin
            check($sformatf("vec%0d_spi_rdata", k), 32'(rd), 32'(vecs[k].exp));
            check($sformatf("vec%0d_rd_no_stb", k), 32'(stb_cnt - s0), 0);
            check($sformatf("vec%0d_t_hi_hdr", k), 32'(th), 1);
            check($sformatf("vec%0d_t_lo_data", k), 32'(tl), 1);
            check($sformatf("vec%0d_t_hi_after", k), 32'(spi_miso_t), 1);
         end else begin
            check($sformatf("vec%0d_stb_count", k), 32'(stb_cnt - s0), (vecs[k].addr != 5'h00) ? 1 : 0);
            check($sformatf("vec%0d_wr_t_hi", k), 32'(t_low_cnt - t0), 0);
            local_read(vecs[k].addr, vecs[k].exp, $sformatf("vec%0d_local_rd", k));
         end
      end

      // Abort after 10 SCLK cycles of a write frame
      s0 = stb_cnt; f0 = frm_cnt;
      spi_frame({1'b0, 10'b0, 5'h12, 8'h00}, 10, rd, th, tl);
      check("abort_frm_pulse", 32'(frm_cnt - f0), 1);
      check("abort_no_stb", 32'(stb_cnt - s0), 0);
      local_read(5'h12, 8'hC3, "abort_reg_kept");
      s0 = stb_cnt; f0 = frm_cnt;
      sb_q.push_back('{5'h05, 8'h5A});
      spi_frame({1'b0, 10'b0, 5'h05, 8'h5A}, 24, rd, th, tl);
      check("post_abort_stb", 32'(stb_cnt - s0), 1);
      check("post_abort_no_err", 32'(frm_cnt - f0), 0);
      local_read(5'h05, 8'h5A, "post_abort_reg");

      // Read with 30 SCLK cycles: trailing edges are ignored
      s0 = stb_cnt; f0 = frm_cnt;
      spi_frame({1'b1, 10'b0, 5'h03, 8'h00}, 30, rd, th, tl);
      check("extra_edges_rdata", 32'(rd), 32'h55);
      check("extra_edges_no_err", 32'(frm_cnt - f0), 0);
      check("extra_edges_no_stb", 32'(stb_cnt - s0), 0);

      // Reset at bit 20 of a write to reg 3
      reg_addr = 5'h03;
      wait_clk(2);
      word = {1'b0, 10'b0, 5'h03, 8'h99};
      spi_cs = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 20; i++) sck_bit(word[23-i], m, t);
      rstn = 1'b0;
      #1;
      check("mid_rst_miso_o", 32'(spi_miso_o), 0);
      check("mid_rst_miso_t", 32'(spi_miso_t), 1);
      check("mid_rst_wr_stb", 32'(wr_stb), 0);
      check("mid_rst_wr_addr", 32'(wr_addr), 0);
      check("mid_rst_wr_data", 32'(wr_data), 0);
      check("mid_rst_rdata", 32'(reg_rdata), 0);
      check("mid_rst_frm_err", 32'(frm_err), 0);
      spi_cs = 1'b1; spi_clk = 1'b1;
      wait_clk(4);
      rstn = 1'b1;
      wait_clk(4);
      local_read(5'h03, 8'h00, "rst_reg3_clear");
      local_read(5'h12, 8'h00, "rst_reg12_clear");
      local_read(5'h00, 8'hA5, "rst_chip_id");
      s0 = stb_cnt; f0 = frm_cnt;
      sb_q.push_back('{5'h03, 8'h77});
      spi_frame({1'b0, 10'b0, 5'h03, 8'h77}, 24, rd, th, tl);
      check("post_rst_stb", 32'(stb_cnt - s0), 1);
      check("post_rst_no_err", 32'(frm_cnt - f0), 0);
      local_read(5'h03, 8'h77, "post_rst_reg3");

      check("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
